// File: rtl/fft_bitrev_buffer_if.sv
// Stream bundle for fft_bitrev_buffer: natural-order samples in, bit-reversed samples out.
interface fft_bitrev_buffer_if #(
  parameter int DATA_W = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_real;
  logic signed [DATA_W-1:0] out_imag;
  logic [2:0]               out_index;
  logic                     out_last;

  modport master (
    output in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_index, out_last
  );

  modport slave (
    input  in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_index, out_last
  );
endinterface

// File: rtl/fft_bitrev_buffer.sv
// 8-point FFT input reorder buffer: fills 8 samples in natural order, drains them bit-reversed.
// Optional macro FFT_IN_SCALE_EN pre-scales every stored sample by >>>3 for three radix-2 stages.
module fft_bitrev_buffer #(
  parameter int DATA_W = 32,
  parameter int N      = 8
) (
  input  logic                clk,
  input  logic                rst,
  fft_bitrev_buffer_if.slave  bus
);

  if (N != 8) begin : g_bad_n
    $error("fft_bitrev_buffer supports only N = 8");
  end

  typedef enum logic {FILL, DRAIN} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } sample_t;

  state_e     state_q, state_d;
  logic [2:0] wr_cnt_q, wr_cnt_d;
  logic [2:0] rd_cnt_q, rd_cnt_d;
  logic       active_q, active_d;
  sample_t    mem_q [8];
  sample_t    mem_d [8];

  logic       in_fire;
  logic       out_fire;
  logic [2:0] rd_index;
  sample_t    wr_sample;

  function automatic logic [2:0] bitrev3(input logic [2:0] c);
    return {c[0], c[1], c[2]};
  endfunction

  always_comb begin
`ifdef FFT_IN_SCALE_EN
    wr_sample.re = bus.in_real >>> 3;
    wr_sample.im = bus.in_imag >>> 3;
`else
    wr_sample.re = bus.in_real;
    wr_sample.im = bus.in_imag;
`endif
  end

  // active_q keeps in_ready low until the first edge after reset releases.
  assign bus.in_ready  = active_q && (state_q == FILL);
  assign bus.out_valid = (state_q == DRAIN);
  assign rd_index      = bitrev3(rd_cnt_q);
  assign bus.out_index = rd_index;
  assign bus.out_real  = mem_q[rd_index].re;
  assign bus.out_imag  = mem_q[rd_index].im;
  assign bus.out_last  = bus.out_valid && (rd_cnt_q == 3'd7);

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    active_d = 1'b1;
    mem_d    = mem_q;

    unique case (state_q)
      FILL: begin
        if (in_fire) begin
          mem_d[wr_cnt_q] = wr_sample;
          wr_cnt_d        = wr_cnt_q + 3'd1;
          if (wr_cnt_q == 3'd7) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          rd_cnt_d = rd_cnt_q + 3'd1;
          if (rd_cnt_q == 3'd7) state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: state updates use <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      wr_cnt_q <= 3'd0;
      rd_cnt_q <= 3'd0;
      active_q <= 1'b0;
      // NOTE: the sample array is reset because outputs read it directly and must be zero in reset.
      for (int i = 0; i < 8; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      active_q <= active_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Bench for fft_bitrev_buffer: table-driven reference frame, corner sequences and a randomized scoreboard.
module tb_fft_bitrev_buffer;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_bitrev_buffer_if #(.DATA_W(DW)) bus ();

  fft_bitrev_buffer #(.DATA_W(DW), .N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         in_re;
    int         in_im;
    int         exp_re;
    int         exp_im;
    logic [2:0] exp_idx;
    logic       exp_last;
  } vec_t;

  typedef struct {
    logic [2:0] idx;
    int         re;
    int         im;
    logic       last;
  } exp_t;

  vec_t tbl [8];
  exp_t sb [$];
  int   mdl_re [8];
  int   mdl_im [8];
  int   mdl_wr = 0;
  int   checks = 0;
  int   errors = 0;

  const int ORDER [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`ifdef FFT_IN_SCALE_EN
  const int EXP_RE [8] = '{0, 128, 64, 192, 32, 160, 96, 224};
  const int EXP_IM [8] = '{0, -128, -64, -192, -32, -160, -96, -224};
`else
  const int EXP_RE [8] = '{0, 1024, 512, 1536, 256, 1280, 768, 1792};
  const int EXP_IM [8] = '{0, -1024, -512, -1536, -256, -1280, -768, -1792};
`endif

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int scale(input int x);
`ifdef FFT_IN_SCALE_EN
    return x >>> 3;
`else
    return x;
`endif
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"},  bus.in_ready,  0);
    check({tag, " out_valid"}, bus.out_valid, 0);
    check({tag, " out_last"},  bus.out_last,  0);
    check({tag, " out_index"}, bus.out_index, 0);
    check({tag, " out_real"},  bus.out_real,  0);
    check({tag, " out_imag"},  bus.out_imag,  0);
  endtask

  // Presents one sample after 'gap' idle cycles; returns at the negedge before the accepting edge.
  task automatic send_one(input int re, input int im, input int gap, input bit use_model);
    int t = 0;
    repeat (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_real  = re;
    bus.in_imag  = im;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      check("in_ready timeout", bus.in_ready, 1);
      return;
    end
    if (use_model) begin
      mdl_re[mdl_wr] = scale(re);
      mdl_im[mdl_wr] = scale(im);
      mdl_wr++;
      if (mdl_wr == 8) begin
        for (int r = 0; r < 8; r++) begin
          exp_t e;
          e.idx  = 3'(ORDER[r]);
          e.re   = mdl_re[ORDER[r]];
          e.im   = mdl_im[ORDER[r]];
          e.last = (r == 7);
          sb.push_back(e);
        end
        mdl_wr = 0;
      end
    end
  endtask

  // Pops 8 expected records; optional junk input traffic and a 5-cycle stall at output number stall_at.
  task automatic drain_frame(input int rdy_pct, input bit junk, input int stall_at);
    int got = 0;
    int budget = 0;
    int stalls = 0;
    exp_t e;
    while (got < 8 && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (junk) begin
        bus.in_valid = 1'b1;
        bus.in_real  = int'($urandom);
        bus.in_imag  = int'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(99) < rdy_pct);
      if (bus.out_valid && got == stall_at && stalls < 5) begin
        bus.out_ready = 1'b0;
        stalls++;
        check("stall out_real held",  bus.out_real,  sb[0].re);
        check("stall out_index held", bus.out_index, sb[0].idx);
      end
      if (bus.out_valid && junk) check("in_ready low in drain", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected output", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_index", bus.out_index, e.idx);
          check("out_real",  bus.out_real,  e.re);
          check("out_imag",  bus.out_imag,  e.im);
          check("out_last",  bus.out_last,  e.last);
        end
        got++;
      end
    end
    if (got < 8) check("drain timeout", got, 8);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("in_ready after drain", bus.in_ready, 1);
    check("out_valid after drain", bus.out_valid, 0);
  endtask

  task automatic run_table_frame(input int rdy_pct, input bit junk, input int stall_at);
    for (int k = 0; k < 8; k++) send_one(tbl[k].in_re, tbl[k].in_im, 0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      exp_t e;
      e.idx  = tbl[k].exp_idx;
      e.re   = tbl[k].exp_re;
      e.im   = tbl[k].exp_im;
      e.last = tbl[k].exp_last;
      sb.push_back(e);
    end
    drain_frame(rdy_pct, junk, stall_at);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      tbl[k].in_re    = k * 256;
      tbl[k].in_im    = -k * 256;
      tbl[k].exp_re   = EXP_RE[k];
      tbl[k].exp_im   = EXP_IM[k];
      tbl[k].exp_idx  = 3'(ORDER[k]);
      tbl[k].exp_last = (k == 7);
    end

    bus.in_valid  = 1'b0;
    bus.in_real   = '0;
    bus.in_imag   = '0;
    bus.out_ready = 1'b0;

    // Reset state and the first edge after release.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    #1 check("in_ready before first edge", bus.in_ready, 0);
    @(negedge clk);
    check("in_ready first edge", bus.in_ready, 1);

    // Reference frame, full throughput.
    run_table_frame(100, 1'b0, -1);
    // Same frame with a 5-cycle stall on the 3rd output.
    run_table_frame(100, 1'b0, 2);
    // Same frame with junk input traffic throughout drain.
    run_table_frame(100, 1'b1, -1);

    // Reset after 5 accepted inputs discards the partial frame.
    for (int k = 0; k < 5; k++) send_one(1000 + k, -1000 - k, 0, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1 check_reset_outputs("mid-fill reset");
    mdl_wr = 0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_table_frame(100, 1'b0, -1);

    // Random gaps and back-pressure over 20 frames.
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 8; k++)
        send_one(int'($urandom), int'($urandom), int'($urandom_range(2)), 1'b1);
      drain_frame(60, f[0], -1);
    end
    check("scoreboard empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
